// File: rtl/sync_fifo_param_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
// Holds the default geometry used by the cpu_top queues and the pointer-width rule.
package sync_fifo_param_pkg;

  // Default data width and depth of a cpu_top queue.
  localparam int FIFO_DEF_WIDTH = 32;
  localparam int FIFO_DEF_DEPTH = 16;

  // Pointers carry one extra wrap bit above the index bits.
  // The occupancy count uses the same width so it can reach DEPTH.
  function automatic int fifo_ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_param_ram.sv
// DEPTH x WIDTH storage for sync_fifo_param.
// One synchronous write port and one read address port.
// The read is asynchronous in first-word-fall-through mode and registered otherwise.
module sync_fifo_param_ram
  import sync_fifo_param_pkg::*;
#(
  parameter int WIDTH = FIFO_DEF_WIDTH,
  parameter int DEPTH = FIFO_DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH),
  parameter bit FWFT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Storage write; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  generate
    if (FWFT) begin : g_async_rd
      // The head entry is simply presented, so the read strobe and reset are not needed here.
      logic w_unused_rd;
      assign w_unused_rd = rd_en & reset_n;
      assign rd_data     = r_mem[rd_addr];
    end else begin : g_sync_rd
      logic [WIDTH-1:0] r_rd_data;
      // Registered read: capture the addressed word only on a popped read, otherwise hold.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_rd_data <= '0;
        end else if (rd_en) begin
          r_rd_data <= r_mem[rd_addr];
        end
      end
      assign rd_data = r_rd_data;
    end
  endgenerate

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, synchronous flush, sticky error
// flags and a selectable first-word-fall-through read mode.
module sync_fifo_param
  import sync_fifo_param_pkg::*;
#(
  parameter int WIDTH    = FIFO_DEF_WIDTH,
  parameter int DEPTH    = FIFO_DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter bit FWFT     = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_valid,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = fifo_ptr_width(DEPTH);
  localparam logic [PW-1:0] AF_THR = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_THR = PW'(AE_LEVEL);

  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_count;
  logic             r_overflow;
  logic             r_underflow;
  logic             w_full;
  logic             w_empty;
  logic             w_wr_acc;
  logic             w_rd_acc;
  logic [WIDTH-1:0] w_ram_rd;

  // Full/empty come from the pre-edge pointers: equal index with differing wrap bit is full.
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);

  // No bypass: a write into a full FIFO or a read from an empty one is refused
  // even when the opposite operation happens in the same cycle.
  assign w_wr_acc = wr_en && !w_full  && !flush;
  assign w_rd_acc = rd_en && !w_empty && !flush;

  // Pointers and the registered occupancy count advance together on accepted operations.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + PW'(1);
        2'b01:   r_count <= r_count - PW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky error flags: set by any refused request, cleared only by flush or reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= r_overflow  | (wr_en && w_full);
      r_underflow <= r_underflow | (rd_en && w_empty);
    end
  end

  sync_fifo_param_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW),
    .FWFT  (FWFT)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (w_wr_acc),
    .wr_addr (r_wr_ptr[AW-1:0]),
    .wr_data (wr_data),
    .rd_en   (w_rd_acc),
    .rd_addr (r_rd_ptr[AW-1:0]),
    .rd_data (w_ram_rd)
  );

  generate
    if (FWFT) begin : g_fwft
      // Head entry is shown while data is present; zero when empty.
      assign rd_valid = !w_empty;
      assign rd_data  = w_empty ? '0 : w_ram_rd;
    end else begin : g_regrd
      logic r_rd_valid;
      // rd_valid marks the cycle right after an accepted pop.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_rd_valid <= 1'b0;
        end else begin
          r_rd_valid <= w_rd_acc;
        end
      end
      assign rd_valid = r_rd_valid;
      assign rd_data  = w_ram_rd;
    end
  endgenerate

  assign full         = w_full;
  assign empty        = w_empty;
  assign count        = r_count;
  assign almost_full  = (r_count >= AF_THR);
  assign almost_empty = (r_count <= AE_THR);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Testbench for sync_fifo_param: a registered-read instance and a FWFT instance
// (DEPTH=4, WIDTH=8, AF_LEVEL=3, AE_LEVEL=1) share one stimulus stream and are
// compared against a queue-based reference model after every clock.
module tb_sync_fifo_param;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int AF = 3;
  localparam int AE = 1;

  logic         clk;
  logic         reset_n;
  logic         flush;
  logic         wr_en;
  logic [W-1:0] wr_data;
  logic         rd_en;

  logic [W-1:0] rd_data      [2];
  logic         rd_valid     [2];
  logic         full         [2];
  logic         empty        [2];
  logic         almost_full  [2];
  logic         almost_empty [2];
  logic [2:0]   count        [2];
  logic         overflow     [2];
  logic         underflow    [2];

  // Reference model state
  logic [W-1:0] q[$];
  logic         m_ovf;
  logic         m_unf;
  logic         m_rvld;
  logic [W-1:0] m_rd0;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  sync_fifo_param #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1'b0)) u_dut_reg (
    .clk(clk), .reset_n(reset_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data[0]), .rd_valid(rd_valid[0]), .full(full[0]), .empty(empty[0]),
    .almost_full(almost_full[0]), .almost_empty(almost_empty[0]), .count(count[0]),
    .overflow(overflow[0]), .underflow(underflow[0])
  );

  sync_fifo_param #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1'b1)) u_dut_fwft (
    .clk(clk), .reset_n(reset_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data[1]), .rd_valid(rd_valid[1]), .full(full[1]), .empty(empty[1]),
    .almost_full(almost_full[1]), .almost_empty(almost_empty[1]), .count(count[1]),
    .overflow(overflow[1]), .underflow(underflow[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    m_rvld = 1'b0;
    m_rd0  = '0;
  endtask

  // Behavioural FIFO: decisions use the occupancy before the edge.
  task automatic model_update(input logic w, input logic [W-1:0] wd, input logic r, input logic f);
    int  sz;
    bit  was_full;
    bit  was_empty;
    sz        = q.size();
    was_full  = (sz == D);
    was_empty = (sz == 0);
    if (f) begin
      q.delete();
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
      m_rvld = 1'b0;
    end else begin
      if (w && was_full)  m_ovf = 1'b1;
      if (r && was_empty) m_unf = 1'b1;
      m_rvld = 1'b0;
      if (r && !was_empty) begin
        m_rd0  = q.pop_front();
        m_rvld = 1'b1;
      end
      if (w && !was_full) q.push_back(wd);
    end
  endtask

  task automatic check_state(input string where);
    int sz;
    sz = q.size();
    for (int i = 0; i < 2; i++) begin
      string s;
      s = $sformatf("%s.%s", where, (i == 0) ? "reg" : "fwft");
      chk({s, ".count"},        32'(count[i]),        32'(sz));
      chk({s, ".empty"},        32'(empty[i]),        32'(sz == 0));
      chk({s, ".full"},         32'(full[i]),         32'(sz == D));
      chk({s, ".almost_full"},  32'(almost_full[i]),  32'(sz >= AF));
      chk({s, ".almost_empty"}, 32'(almost_empty[i]), 32'(sz <= AE));
      chk({s, ".overflow"},     32'(overflow[i]),     32'(m_ovf));
      chk({s, ".underflow"},    32'(underflow[i]),    32'(m_unf));
    end
    chk({where, ".reg.rd_valid"},  32'(rd_valid[0]), 32'(m_rvld));
    chk({where, ".reg.rd_data"},   32'(rd_data[0]),  32'(m_rd0));
    chk({where, ".fwft.rd_valid"}, 32'(rd_valid[1]), 32'(sz != 0));
    chk({where, ".fwft.rd_data"},  32'(rd_data[1]),  (sz != 0) ? 32'(q[0]) : 32'd0);
  endtask

  // One clock: drive inputs, advance the model at the edge, check 1 time unit later.
  task automatic step(input string where, input logic w, input logic [W-1:0] wd,
                      input logic r, input logic f);
    wr_en   = w;
    wr_data = wd;
    rd_en   = r;
    flush   = f;
    @(posedge clk);
    model_update(w, wd, r, f);
    #1;
    check_state(where);
    $display("step %-10s wr=%0b wd=%02h rd=%0b fl=%0b -> cnt=%0d rd_reg=%02h/%0b rd_fwft=%02h",
             where, w, wd, r, f, count[0], rd_data[0], rd_valid[0], rd_data[1]);
  endtask

  initial begin
    reset_n = 1'b0;
    flush   = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    rd_en   = 1'b0;
    model_reset();
    #12;
    check_state("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Fill, overflow, drain
    step("fill", 1'b1, 8'h11, 1'b0, 1'b0);
    step("fill", 1'b1, 8'h22, 1'b0, 1'b0);
    step("fill", 1'b1, 8'h33, 1'b0, 1'b0);
    step("fill", 1'b1, 8'h44, 1'b0, 1'b0);
    step("ovf",  1'b1, 8'h55, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step("drain", 1'b0, 8'h00, 1'b1, 1'b0);

    // Underflow then flush clears both sticky flags
    step("unf",   1'b0, 8'h00, 1'b1, 1'b0);
    step("flush", 1'b0, 8'h00, 1'b0, 1'b1);

    // FWFT visibility and pop-to-empty
    step("fwft_wr", 1'b1, 8'hA5, 1'b0, 1'b0);
    step("fwft_rd", 1'b0, 8'h00, 1'b1, 1'b0);

    // Simultaneous read/write at count 2, at full and at empty
    step("sim", 1'b1, 8'h01, 1'b0, 1'b0);
    step("sim", 1'b1, 8'h02, 1'b0, 1'b0);
    step("sim2", 1'b1, 8'h03, 1'b1, 1'b0);
    step("sim", 1'b1, 8'h04, 1'b0, 1'b0);
    step("sim", 1'b1, 8'h05, 1'b0, 1'b0);
    step("simfull", 1'b1, 8'h06, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step("sim", 1'b0, 8'h00, 1'b1, 1'b0);
    step("simempty", 1'b1, 8'h07, 1'b1, 1'b0);
    step("sim", 1'b0, 8'h00, 1'b1, 1'b0);

    // Pointer wrap: 10 writes interleaved with reads, then drain
    for (int i = 0; i < 10; i++) step("wrap", 1'b1, 8'(8'h80 + i), (i % 3) != 0, 1'b0);
    for (int i = 0; i < 4; i++) step("wrapdrn", 1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset mid-burst at count 3
    step("preRst", 1'b1, 8'hC1, 1'b0, 1'b0);
    step("preRst", 1'b1, 8'hC2, 1'b0, 1'b0);
    step("preRst", 1'b1, 8'hC3, 1'b1, 1'b0);
    step("preRst", 1'b1, 8'hC4, 1'b0, 1'b0);
    wr_data = 8'hC5;
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_state("async_rst");
    @(negedge clk);
    check_state("rst_held");
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    reset_n = 1'b1;
    step("postRst", 1'b1, 8'h5A, 1'b0, 1'b0);
    step("postRst", 1'b0, 8'h00, 1'b1, 1'b0);

    // Randomised traffic with occasional flushes
    for (int i = 0; i < 300; i++) begin
      logic w;
      logic r;
      logic f;
      w = ($urandom_range(0, 99) < ((q.size() < 2) ? 70 : 45));
      r = ($urandom_range(0, 99) < 50);
      f = ($urandom_range(0, 39) == 0);
      step("rand", w, 8'($urandom), r, f);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
